vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares one single-port synchronous video RAM (1-cycle read latency) between two requesters.
//  - VGA scanout fetch: read-only, latency-critical.
//  - CPU load/store port: read/write, stallable.
//  Sits between the memory-mapped CPU bus and the texture store feeding the painter/scanout path.
//  VGA wins during the active display area; CPU wins during blanking.
//  A wait counter bounds CPU starvation.
// PARAMETERS
//  ADDR_W        16  word address width of video RAM
//  DATA_W        32  data word width
//  CPU_MAX_WAIT  4   max consecutive cycles a pending CPU request loses to VGA; 0 = CPU always wins
// PORTS
//  clk           in   1       system clock, all logic on rising edge
//  reset         in   1       synchronous, active-high
//  vga_active    in   1       1 = scanout in display area (VGA priority), 0 = blanking (CPU priority)
//  vga_req       in   1       VGA read request
//  vga_addr      in   ADDR_W  VGA read word address
//  vga_gnt       out  1       VGA request accepted this cycle
//  vga_rvalid    out  1       vga_rdata valid
//  vga_rdata     out  DATA_W  VGA read data
//  cpu_req       in   1       CPU request
//  cpu_we        in   1       1 = write, 0 = read
//  cpu_addr      in   ADDR_W  CPU word address
//  cpu_wdata     in   DATA_W  CPU write data
//  cpu_gnt       out  1       CPU request accepted this cycle (stall = cpu_req & ~cpu_gnt)
//  cpu_rvalid    out  1       cpu_rdata valid (reads only)
//  cpu_rdata     out  DATA_W  CPU read data
//  mem_en        out  1       RAM access enable
//  mem_we        out  1       RAM write enable
//  mem_addr      out  ADDR_W  RAM address
//  mem_wdata     out  DATA_W  RAM write data
//  mem_rdata     in   DATA_W  RAM read data, valid 1 cycle after mem_en & ~mem_we
// BEHAVIOUR
//  - Handshake: transfer occurs when req & gnt in the same cycle.
//    - Requester holds req, addr, we and wdata stable until granted.
//    - At most one grant per cycle.
//  - Grant decision is combinational from inputs and the registered wait counter (wcnt).
//    - Only cpu_req: CPU. Only vga_req: VGA. Neither: no grant, mem_en=0.
//    - Both requesting:
//      - vga_active=0: CPU wins.
//      - vga_active=1 and wcnt < CPU_MAX_WAIT: VGA wins.
//      - vga_active=1 and wcnt == CPU_MAX_WAIT: CPU wins (forced).
//  - Memory drive:
//    - mem_en = vga_gnt | cpu_gnt.
//    - mem_addr = addr of the granted requester.
//    - mem_we = cpu_gnt & cpu_we.
//    - mem_wdata = cpu_wdata.
//    - With no grant: mem_addr, mem_we and mem_wdata are 0.
//  - wcnt (saturating at CPU_MAX_WAIT):
//    - cpu_req & ~cpu_gnt: +1.
//    - cpu_gnt or ~cpu_req: cleared to 0.
//  - Read return:
//    - Registered owner tag {vga, cpu_rd} captured at grant.
//    - Next cycle, exactly one of vga_rvalid / cpu_rvalid pulses for one cycle.
//    - Both rdata outputs carry mem_rdata combinationally; valid only with their rvalid.
//    - CPU writes produce no rvalid.
//  - Latency: grant to rvalid is exactly 1 cycle. Back-to-back grants sustain 1 access per cycle.
//  - Reset:
//    - wcnt=0, owner tag cleared.
//    - vga_rvalid = cpu_rvalid = 0.
//    - vga_gnt = cpu_gnt = mem_en = mem_we = 0 while reset is high, regardless of requests.
//    - Reset mid-read: the pending rvalid is dropped and not replayed.
//  - A vga_active toggle takes effect on the same cycle's decision. The counter is not cleared by the toggle.
//  - No address range check: addresses pass through unmodified.
// TESTING
//  - reset=1 with vga_req=cpu_req=1 -> all grants, mem_en and rvalids 0. Release -> first decision the next cycle.
//  - VGA reads only, addr 0..7 back-to-back, RAM preloaded with addr*3 -> vga_gnt every cycle; vga_rvalid 1 cycle later with data 0,3,...,21.
//  - vga_active=1, both requesting continuously, CPU_MAX_WAIT=4 -> grants follow VGA x4, CPU x1, repeating. cpu_gnt on cycles 4,9,14.
//  - vga_active=0, both requesting, CPU write addr 5 data 32'hDEADBEEF -> cpu_gnt same cycle, mem_we=1, no rvalid. Then VGA read addr 5 -> vga_rdata = 32'hDEADBEEF.
//  - CPU read granted in cycle N, reset asserted in cycle N+1 -> cpu_rvalid stays 0. wcnt=0 after reset.
//  - CPU_MAX_WAIT=0, vga_active=1, both requesting -> CPU granted every cycle; VGA is never granted while cpu_req is held.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous video RAM between VGA scanout reads and CPU load/store.
// Ports: clk/reset (sync, active-high); vga_active selects priority (1 = VGA, 0 = CPU);
// vga_req/addr -> vga_gnt, vga_rvalid/rdata; cpu_req/we/addr/wdata -> cpu_gnt, cpu_rvalid/rdata;
// mem_en/we/addr/wdata drive the RAM, whose mem_rdata returns one cycle after a read.
module vram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_active,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int WCNT_W = CPU_MAX_WAIT > 0 ? $clog2(CPU_MAX_WAIT + 1) : 1;
  localparam logic [WCNT_W-1:0] WMAX = WCNT_W'(CPU_MAX_WAIT);
  logic [WCNT_W-1:0] wcnt;
  logic vga_tag, cpu_tag, cpu_wins;
  // CPU loses to VGA only in the display area, and only until it has waited WMAX cycles
  assign cpu_wins   = cpu_req & (~vga_req | ~vga_active | (wcnt == WMAX));
  assign cpu_gnt    = ~reset & cpu_wins;
  assign vga_gnt    = ~reset & vga_req & ~cpu_wins;
  assign mem_en     = vga_gnt | cpu_gnt;
  assign mem_we     = cpu_gnt & cpu_we;
  assign mem_addr   = cpu_gnt ? cpu_addr : vga_gnt ? vga_addr : '0;
  assign mem_wdata  = mem_en ? cpu_wdata : '0;
  // a read in flight during reset is dropped, not delivered afterwards
  assign vga_rvalid = vga_tag & ~reset;
  assign cpu_rvalid = cpu_tag & ~reset;
  assign vga_rdata  = mem_rdata;
  assign cpu_rdata  = mem_rdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt    <= '0;
      vga_tag <= 1'b0;
      cpu_tag <= 1'b0;
    end else begin
      wcnt    <= (cpu_req & ~cpu_gnt) ? ((wcnt == WMAX) ? wcnt : wcnt + 1'b1) : '0;
      vga_tag <= vga_gnt;
      cpu_tag <= cpu_gnt & ~cpu_we;
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and randomized checks of vram_arbiter against a behavioural model.
module tb_vram_arbiter;
  logic clk = 1'b0, reset = 1'b1, vga_active = 1'b0, vga_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] vga_addr = '0, cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic vga_gnt, vga_rvalid, cpu_gnt, cpu_rvalid, mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] vga_rdata, cpu_rdata, mem_wdata, ram_q;
  logic b_vga_gnt, b_vga_rvalid, b_cpu_gnt, b_cpu_rvalid, b_mem_en, b_mem_we;
  logic [15:0] b_mem_addr;
  logic [31:0] b_vga_rdata, b_cpu_rdata, b_mem_wdata;
  logic [31:0] ram [256];
  logic [31:0] shadow [256];
  int n_cmp = 0, n_bad = 0, wait_a = 0, wait_b = 0;
  logic exp_vrv = 1'b0, exp_crv = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic [1:0] last_g = '0;

  vram_arbiter #(.ADDR_W(16), .DATA_W(32), .CPU_MAX_WAIT(4)) dut_a (
    .clk(clk), .reset(reset), .vga_active(vga_active),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(ram_q)
  );

  vram_arbiter #(.ADDR_W(16), .DATA_W(32), .CPU_MAX_WAIT(0)) dut_b (
    .clk(clk), .reset(reset), .vga_active(vga_active),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(b_vga_gnt), .vga_rvalid(b_vga_rvalid), .vga_rdata(b_vga_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(b_cpu_gnt), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else ram_q <= ram[mem_addr[7:0]];
    end

  // expected {vga, cpu} grant from the arbitration rules; w = cycles the pending CPU request has lost so far
  function automatic logic [1:0] pick(int w, int maxw);
    if (reset) return 2'b00;
    if (cpu_req && (!vga_req || !vga_active || w >= maxw)) return 2'b01;
    if (vga_req) return 2'b10;
    return 2'b00;
  endfunction

  task automatic advance();
    logic [1:0] g, h;
    g = pick(wait_a, 4);
    h = pick(wait_b, 0);
    @(posedge clk);
    exp_vrv = g[1];
    exp_crv = g[0] && !cpu_we;
    if (g[0] && cpu_we) shadow[cpu_addr[7:0]] = cpu_wdata;
    if (g[1]) exp_rdata = shadow[vga_addr[7:0]];
    else if (exp_crv) exp_rdata = shadow[cpu_addr[7:0]];
    wait_a = (!reset && cpu_req && !g[0]) ? wait_a + 1 : 0;
    wait_b = (!reset && cpu_req && !h[0]) ? wait_b + 1 : 0;
    last_g = g;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; vga_req = 1'b1; cpu_req = 1'b1; vga_active = 1'b1; cpu_we = 1'b0;
    repeat (2) begin
      #1;
      n_cmp++;
      if ({vga_gnt, cpu_gnt, mem_en, mem_we, vga_rvalid, cpu_rvalid} !== 6'b0) begin
        n_bad++; $display("FAIL reset_a: got %b want 000000", {vga_gnt, cpu_gnt, mem_en, mem_we, vga_rvalid, cpu_rvalid});
      end
      n_cmp++;
      if ({b_vga_gnt, b_cpu_gnt, b_mem_en, b_mem_we, b_vga_rvalid, b_cpu_rvalid} !== 6'b0) begin
        n_bad++; $display("FAIL reset_b: got %b want 000000", {b_vga_gnt, b_cpu_gnt, b_mem_en, b_mem_we, b_vga_rvalid, b_cpu_rvalid});
      end
      advance();
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({vga_gnt, cpu_gnt, mem_en} !== 3'b101) begin
      n_bad++; $display("FAIL release_a: got %b want 101", {vga_gnt, cpu_gnt, mem_en});
    end
    n_cmp++;
    if ({b_vga_gnt, b_cpu_gnt} !== 2'b01) begin
      n_bad++; $display("FAIL release_b: got %b want 01", {b_vga_gnt, b_cpu_gnt});
    end
    advance();
    vga_req = 1'b0; cpu_req = 1'b0;
    advance();
  endtask

  task automatic test_vga_stream();
    vga_active = 1'b1; cpu_req = 1'b0;
    for (int a = 0; a < 9; a++) begin
      vga_req = (a < 8);
      vga_addr = 16'(a);
      #1;
      n_cmp++;
      if (vga_gnt !== (a < 8) || mem_addr !== ((a < 8) ? 16'(a) : 16'h0)) begin
        n_bad++; $display("FAIL stream_gnt[%0d]: got gnt=%b addr=%h want gnt=%b", a, vga_gnt, mem_addr, a < 8);
      end
      n_cmp++;
      if (vga_rvalid !== (a > 0) || cpu_rvalid !== 1'b0) begin
        n_bad++; $display("FAIL stream_rvalid[%0d]: got v=%b c=%b want v=%b c=0", a, vga_rvalid, cpu_rvalid, a > 0);
      end
      if (a > 0) begin
        n_cmp++;
        if (vga_rdata !== 32'((a - 1) * 3)) begin
          n_bad++; $display("FAIL stream_data[%0d]: got %h want %h", a, vga_rdata, 32'((a - 1) * 3));
        end
      end
      advance();
    end
  endtask

  task automatic test_starvation();
    vga_active = 1'b1; vga_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    cpu_addr = 16'h0040; vga_addr = 16'h0010;
    for (int c = 0; c < 15; c++) begin
      #1;
      n_cmp++;
      if ({vga_gnt, cpu_gnt} !== ((c % 5 == 4) ? 2'b01 : 2'b10)) begin
        n_bad++; $display("FAIL starve_a[%0d]: got %b want %b", c, {vga_gnt, cpu_gnt}, (c % 5 == 4) ? 2'b01 : 2'b10);
      end
      n_cmp++;
      if ({b_vga_gnt, b_cpu_gnt} !== 2'b01) begin
        n_bad++; $display("FAIL starve_b[%0d]: got %b want 01", c, {b_vga_gnt, b_cpu_gnt});
      end
      n_cmp++;
      if ({vga_rvalid, cpu_rvalid} !== {exp_vrv, exp_crv} || ((vga_rvalid || cpu_rvalid) && vga_rdata !== exp_rdata)) begin
        n_bad++; $display("FAIL starve_ret[%0d]: got v=%b c=%b d=%h want v=%b c=%b d=%h", c, vga_rvalid, cpu_rvalid, vga_rdata, exp_vrv, exp_crv, exp_rdata);
      end
      advance();
      if (last_g[1]) vga_addr = vga_addr + 16'h1;
    end
    vga_req = 1'b0; cpu_req = 1'b0;
    advance();
  endtask

  task automatic test_write_blank();
    vga_active = 1'b0; vga_req = 1'b1; vga_addr = 16'h0009;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0005; cpu_wdata = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if ({vga_gnt, cpu_gnt, mem_en, mem_we} !== 4'b0111 || mem_addr !== 16'h0005 || mem_wdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL write_drive: got g=%b%b en=%b we=%b a=%h d=%h", vga_gnt, cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    advance();
    cpu_req = 1'b0; cpu_we = 1'b0; vga_addr = 16'h0005;
    #1;
    n_cmp++;
    if ({vga_gnt, vga_rvalid, cpu_rvalid} !== 3'b100 || mem_addr !== 16'h0005) begin
      n_bad++; $display("FAIL write_norv: got gnt=%b v=%b c=%b a=%h want 100 a=0005", vga_gnt, vga_rvalid, cpu_rvalid, mem_addr);
    end
    advance();
    vga_req = 1'b0;
    #1;
    n_cmp++;
    if (vga_rvalid !== 1'b1 || vga_rdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL write_readback: got v=%b d=%h want 1 deadbeef", vga_rvalid, vga_rdata);
    end
    advance();
  endtask

  task automatic test_reset_mid_read();
    vga_active = 1'b0; vga_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0007;
    #1;
    n_cmp++;
    if (cpu_gnt !== 1'b1) begin
      n_bad++; $display("FAIL midread_gnt: got %b want 1", cpu_gnt);
    end
    advance();
    reset = 1'b1; cpu_req = 1'b0;
    #1;
    n_cmp++;
    if ({cpu_rvalid, vga_rvalid} !== 2'b00) begin
      n_bad++; $display("FAIL midread_drop: got c=%b v=%b want 00", cpu_rvalid, vga_rvalid);
    end
    advance();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (cpu_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL midread_replay: got %b want 0", cpu_rvalid);
    end
    advance();
    vga_active = 1'b1; vga_req = 1'b1; cpu_req = 1'b1;
    repeat (3) advance();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({vga_gnt, cpu_gnt, mem_en} !== 3'b000) begin
      n_bad++; $display("FAIL midwait_reset: got %b want 000", {vga_gnt, cpu_gnt, mem_en});
    end
    advance();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if ({vga_gnt, cpu_gnt} !== ((c == 4) ? 2'b01 : 2'b10)) begin
        n_bad++; $display("FAIL wcnt_cleared[%0d]: got %b want %b", c, {vga_gnt, cpu_gnt}, (c == 4) ? 2'b01 : 2'b10);
      end
      advance();
    end
    vga_req = 1'b0; cpu_req = 1'b0;
    advance();
  endtask

  task automatic test_random();
    logic [1:0] g, h;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(99) < 3);
      if ($urandom_range(9) == 0) vga_active = ~vga_active;
      if (!vga_req || last_g[1]) begin
        vga_req = ($urandom_range(3) != 0); vga_addr = 16'($urandom);
      end
      if (!cpu_req || last_g[0]) begin
        cpu_req = ($urandom_range(1) == 1); cpu_we = ($urandom_range(1) == 1);
        cpu_addr = 16'($urandom); cpu_wdata = $urandom;
      end
      #1;
      g = pick(wait_a, 4);
      h = pick(wait_b, 0);
      n_cmp++;
      if ({vga_gnt, cpu_gnt} !== g || {b_vga_gnt, b_cpu_gnt} !== h) begin
        n_bad++; $display("FAIL rand_gnt[%0d]: got a=%b b=%b want a=%b b=%b", n, {vga_gnt, cpu_gnt}, {b_vga_gnt, b_cpu_gnt}, g, h);
      end
      n_cmp++;
      if (mem_en !== (g != 2'b00) || mem_we !== (g[0] && cpu_we) ||
          mem_addr !== (g[0] ? cpu_addr : g[1] ? vga_addr : 16'h0) || mem_wdata !== ((g != 2'b00) ? cpu_wdata : 32'h0)) begin
        n_bad++; $display("FAIL rand_mem[%0d]: got en=%b we=%b a=%h d=%h grant=%b", n, mem_en, mem_we, mem_addr, mem_wdata, g);
      end
      n_cmp++;
      if ({vga_rvalid, cpu_rvalid} !== ({exp_vrv, exp_crv} & {2{!reset}}) ||
          (vga_rvalid && vga_rdata !== exp_rdata) || (cpu_rvalid && cpu_rdata !== exp_rdata)) begin
        n_bad++; $display("FAIL rand_ret[%0d]: got v=%b c=%b d=%h want v=%b c=%b d=%h", n, vga_rvalid, cpu_rvalid, vga_rdata, exp_vrv && !reset, exp_crv && !reset, exp_rdata);
      end
      advance();
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'(i * 3);
      shadow[i] = 32'(i * 3);
    end
    ram_q = '0;
    @(negedge clk);
    test_reset();
    test_vga_stream();
    test_starvation();
    test_write_blank();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
